// File: rtl/fifomem.sv
// Storage for fifo1: 2**ASIZE x DSIZE words, synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifomem #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             wclk,
    input  logic             wclken,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem [DEPTH];

    always_ff @(posedge wclk) begin
        if (wclken) mem[waddr] <= wdata;
    end

    // Combinational read gives first-word-fall-through at the top level.
    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo1.sv
// Single-clock FIFO. The pointers carry one extra wrap bit, and both flags are
// registered from the next-state pointers, so they settle on the same edge as the data.
module fifo1 #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty
);

    logic [ASIZE:0] wptr_q, wptr_d;
    logic [ASIZE:0] rptr_q, rptr_d;
    logic           wfull_q, wfull_d;
    logic           rempty_q, rempty_d;
    logic           do_write, do_read;

    always_comb begin
        do_write = winc & ~wfull_q;
        do_read  = rinc & ~rempty_q;
        wptr_d   = wptr_q + {{ASIZE{1'b0}}, do_write};
        rptr_d   = rptr_q + {{ASIZE{1'b0}}, do_read};
        rempty_d = (wptr_d == rptr_d);
        // Full means the write pointer is exactly one lap ahead of the read pointer.
        wfull_d  = (wptr_d[ASIZE] != rptr_d[ASIZE]) &&
                   (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]);
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            wfull_q  <= wfull_d;
            rempty_q <= rempty_d;
        end
    end

    assign wfull  = wfull_q;
    assign rempty = rempty_q;

    fifomem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .wclk   (wclk),
        .wclken (do_write),
        .waddr  (wptr_q[ASIZE-1:0]),
        .wdata  (wdata),
        .raddr  (rptr_q[ASIZE-1:0]),
        .rdata  (rdata)
    );

endmodule

// File: tb/tb_fifo1.sv
// Self-checking bench for fifo1: directed phases plus random traffic, all
// compared against a queue-based occupancy/order model.
module tb_fifo1;

    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int DEPTH = 1 << ASIZE;

    logic             wclk = 1'b0;
    logic             wrst = 1'b1;
    logic [DSIZE-1:0] wdata = '0;
    logic             winc = 1'b0;
    logic             rinc = 1'b0;
    logic [DSIZE-1:0] rdata;
    logic             wfull;
    logic             rempty;

    int tests = 0;
    int fails = 0;
    int writes_done = 0;
    logic [DSIZE-1:0] q [$];

    fifo1 #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .wclk   (wclk),
        .wrst   (wrst),
        .wdata  (wdata),
        .winc   (winc),
        .rinc   (rinc),
        .rdata  (rdata),
        .wfull  (wfull),
        .rempty (rempty)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, " rempty"}, {31'd0, rempty}, {31'd0, q.size() == 0});
        chk({tag, " wfull"},  {31'd0, wfull},  {31'd0, q.size() == DEPTH});
        if (q.size() != 0) chk({tag, " rdata"}, {24'd0, rdata}, {24'd0, q[0]});
    endtask

    // Drive one cycle from the negedge, apply the queue rules at the posedge, check at the next negedge.
    task automatic step(input logic w, input logic [DSIZE-1:0] d, input logic r, input string tag);
        bit was_full, was_empty;
        winc = w; wdata = d; rinc = r;
        @(posedge wclk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (r && !was_empty) void'(q.pop_front());
        if (w && !was_full) begin
            q.push_back(d);
            writes_done++;
        end
        @(negedge wclk);
        winc = 1'b0; rinc = 1'b0;
        check_state(tag);
    endtask

    initial begin
        // Reset held for 10 cycles, then a single write falls through.
        repeat (10) @(negedge wclk);
        chk("reset rempty", {31'd0, rempty}, 32'd1);
        chk("reset wfull",  {31'd0, wfull},  32'd0);
        wrst = 1'b0;
        step(1'b1, 8'h24, 1'b0, "first write");
        chk("first rdata", {24'd0, rdata}, 32'h24);
        step(1'b0, 8'h00, 1'b1, "drain first");

        // Fill to full, attempt overflow, drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, "fill");
        chk("full after fill", {31'd0, wfull}, 32'd1);
        step(1'b1, 8'hAA, 1'b0, "overflow");
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain order", {24'd0, rdata}, i);
            step(1'b0, 8'h00, 1'b1, "drain");
        end
        chk("empty after drain", {31'd0, rempty}, 32'd1);

        // Alternating write/read traffic across several pointer laps.
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 8'($urandom), 1'b0, "alt write");
            step(1'b0, 8'h00, 1'b1, "alt read");
            chk("alt never full", {31'd0, wfull}, 32'd0);
        end

        // Concurrent push/pop with 5 words held.
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, "hold5 fill");
        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1, "both mid");
        chk("occupancy kept", q.size(), 32'd5);
        while (q.size() < DEPTH) step(1'b1, 8'($urandom), 1'b0, "to full");
        step(1'b1, 8'h5A, 1'b1, "both full");
        chk("both full wfull", {31'd0, wfull}, 32'd0);
        while (q.size() > 0) step(1'b0, 8'h00, 1'b1, "to empty");
        step(1'b1, 8'hC3, 1'b1, "both empty");
        chk("both empty rdata", {24'd0, rdata}, 32'hC3);
        step(1'b0, 8'h00, 1'b1, "pop c3");

        // Underflow attempts must not move the pointers.
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, "underflow");
        step(1'b1, 8'h77, 1'b0, "after underflow");
        chk("after underflow rdata", {24'd0, rdata}, 32'h77);

        // Random mixed traffic.
        for (int i = 0; i < 300; i++)
            step(1'($urandom), 8'($urandom), 1'($urandom_range(0, 2) == 0), "random");

        // Mid-operation reset discards everything immediately.
        while (q.size() < 7) step(1'b1, 8'($urandom), 1'b0, "pre reset");
        while (q.size() > 7) step(1'b0, 8'h00, 1'b1, "pre reset");
        #2 wrst = 1'b1;
        #1;
        chk("async reset rempty", {31'd0, rempty}, 32'd1);
        chk("async reset wfull",  {31'd0, wfull},  32'd0);
        q.delete();
        @(negedge wclk);
        wrst = 1'b0;
        step(1'b0, 8'h00, 1'b1, "post reset read");
        step(1'b1, 8'h3C, 1'b0, "post reset write");
        chk("post reset rdata", {24'd0, rdata}, 32'h3C);
        step(1'b0, 8'h00, 1'b1, "post reset drain");

        if (writes_done < 3 * DEPTH) begin
            fails++;
            $error("FAIL wrap coverage: observed %0d writes expected >= %0d", writes_done, 3 * DEPTH);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
